// File: rtl/memory_bus_master.sv
// Single-request initiator for a shared-bus Memory: sequences wr/rd strobes and owns the data-bus driver.
// Latency: write accept->rsp 2 cycles (3-cycle issue), read accept->rsp 3 cycles (4-cycle issue).
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse with no response backpressure.
module memory_bus_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wr,
    output logic                  mem_rd
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ_CMD = 3'd2,
        READ_CAP = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  bus_oe;
    logic                  accept;

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = req_wr ? WRITE : READ_CMD;
            WRITE:    state_nxt = RESP;
            READ_CMD: state_nxt = READ_CAP;
            READ_CAP: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_wr    = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        bus_oe    = 1'b0;
        case (state)
            IDLE:     req_ready = 1'b1;
            WRITE: begin
                mem_wr = 1'b1;
                bus_oe = 1'b1;
            end
            READ_CMD: mem_rd = 1'b1;
            READ_CAP: mem_rd = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_wr    = lat_wr;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Request fields are held for the whole transaction so mem_addr stays stable through READ_CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (state == READ_CAP) begin
            rsp_rdata <= mem_data;
        end
    end

    assign mem_addr = lat_addr;
    assign mem_data = bus_oe ? lat_wdata : {DATA_WIDTH{1'bz}};

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_wr && mem_rd));

endmodule

// File: doc/memory_bus_master.md
# memory_bus_master

Initiator-side controller for the single-port `Memory` block's shared bus: `addr`, a bidirectional tristate `data`, `wr` and `rd`. It accepts one read or write request at a time from a client over a valid/ready handshake and sequences the memory strobes. It also owns the tristate driver on the data bus and returns one response per request. It sits between any client (CPU stub, DMA, test driver) and a `Memory` instance with matching `ADDR_WIDTH`/`DATA_WIDTH`.

## Interface
- `ADDR_WIDTH`, default 5: memory address width; must match the attached `Memory`.
- `DATA_WIDTH`, default 8: memory data width; must match the attached `Memory`.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: client request present.
- `req_ready` output 1: controller can accept a request this cycle.
- `req_wr` input 1: 1 = write, 0 = read; sampled on acceptance.
- `req_addr` input ADDR_WIDTH: request address; sampled on acceptance.
- `req_wdata` input DATA_WIDTH: write data; sampled on acceptance and ignored for reads.
- `rsp_valid` output 1: one-cycle pulse marking request completion.
- `rsp_wr` output 1: type of the completed request.
- `rsp_rdata` output DATA_WIDTH: read data; valid with `rsp_valid` when `rsp_wr`=0.
- `mem_addr` output ADDR_WIDTH: address to `Memory.addr`.
- `mem_data` inout DATA_WIDTH: connects to `Memory.data`.
- `mem_wr` output 1: to `Memory.wr`.
- `mem_rd` output 1: to `Memory.rd`.

## Operation
- The FSM has five states: IDLE, WRITE, READ_CMD, READ_CAP, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch `req_wr`/`req_addr`/`req_wdata` into internal registers.
  - Go to WRITE if `req_wr`=1, otherwise READ_CMD.
- **WRITE**
  - `mem_wr`=1, `mem_rd`=0, `mem_addr`=latched address.
  - `mem_data` is driven with the latched write data; this is the only state in which the controller drives the bus.
  - `Memory` captures the data on the rising edge that ends this state.
  - Next state: RESP.
- **READ_CMD**
  - `mem_rd`=1, `mem_wr`=0, `mem_addr`=latched address, `mem_data`=Z.
  - `Memory` samples `rd` on the closing edge and drives the data bus.
  - Next state: READ_CAP.
- **READ_CAP**
  - `mem_rd`=1, `mem_addr` held, `mem_data`=Z.
  - `rsp_rdata` is loaded from `mem_data` on the closing edge.
  - Next state: RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_wr`=latched type; `mem_wr`=`mem_rd`=0; bus released.
  - Next state: IDLE unconditionally. There is no response backpressure; the client must consume the pulse.
- **Bus-contention rule.** The output enable for `mem_data` is asserted only in WRITE. `mem_wr` and `mem_rd` are never both 1.
- **Turnaround.** RESP always separates a read from the next write, so the bus is released for at least one cycle between `Memory` driving it and the controller driving it.
- **Requests while busy.** `req_valid` outside IDLE is ignored because `req_ready`=0. The request is taken in the first IDLE cycle in which it is still asserted.
- **Held read data.** `rsp_rdata` holds its last read value after RESP, until the next READ_CAP. Writes do not modify it.
- **Address range.** The full address range 0 .. 2^ADDR_WIDTH−1 is legal. There is no wrap or bounds logic.
- **Reset**
  - Asynchronous; forces IDLE immediately.
  - Drives `mem_wr`=0, `mem_rd`=0, `mem_addr`=0, `mem_data`=Z, `rsp_valid`=0, `rsp_wr`=0, `rsp_rdata`=0.
  - `req_ready` follows IDLE, so it is 1 while reset is asserted and after release.
- **Reset mid-operation** aborts the transaction without a response.
  - A write aborted before its WRITE closing edge leaves memory unmodified.

## Timing
- **Outputs.** All outputs are registered or state-decoded; none has a combinational path from `req_*` inputs.
- **Write.** Accepted at edge E0 → `mem_wr` high E0–E1 → `rsp_valid` high E1–E2 → `req_ready` high from E2. Issue rate is one write per 3 cycles.
- **Read.** Accepted at E0 → `mem_rd` high E0–E2 → data captured at E2 → `rsp_valid` and `rsp_rdata` valid E2–E3 → `req_ready` from E3. Issue rate is one read per 4 cycles.
- **Memory read-data requirement.** `Memory` must present read data on the bus no later than setup before E2, i.e. within one cycle of sampling `rd`.

## Test plan
- **Write then read, address 0.** Write 0xF0 to address 0, then read address 0 → `mem_wr` high for exactly 1 cycle; `rsp_valid` pulses; the read returns `rsp_rdata`=0xF0 with `rsp_wr`=0.
- **Boundary addresses.** Write 0x0F to address 31 and 0xAA to address 21, then read both → 0x0F and 0xAA respectively; address 0 still reads 0xF0.
- **Back-to-back traffic.** Hold `req_valid`=1 with alternating write/read to address 10 (data 0x55) → `req_ready` pattern is 1,0,0,1,0,0,0,1; the read returns 0x55; exactly one `rsp_valid` per request.
- **Bus discipline.** Every cycle of a mixed random sequence is checked → `mem_data` is Z whenever `mem_rd`=1; `mem_wr`&`mem_rd` is never 1; at least one released cycle separates `mem_rd` falling from the next `mem_wr` rising.
- **Reset mid-read.** Assert `rst` asynchronously mid-cycle during READ_CAP → `mem_rd`, `rsp_valid` and `rsp_rdata` go to 0 immediately; no `rsp_valid` is issued; `req_ready`=1; a subsequent read completes normally.
- **Reset mid-write.** Assert `rst` in WRITE before its closing edge, with write data 0x99 to address 5 (previously 0x00) → a later read of address 5 returns 0x00.
